// File: rtl/mul_execute_unit.sv
// mul_execute_unit: multi-cycle shift-add multiplier for the EX stage.
// Launches on MUL_OP with a valid instruction, stalls the pipeline while it
// iterates one multiplier bit per cycle, then pulses done_o with the low
// DATA_WIDTH bits of the product on result_o.
// Ports:
//   clk, reset          - rising-edge clock, async active-low reset
//   ALU_Operation_i     - operation code from ALU control
//   valid_i, flush_i    - EX holds a real instruction / abort in-flight multiply
//   rs1_data_i/rs2_data_i - multiplicand / multiplier
//   stall_o             - hold IF/ID/EX (combinational: includes launch cycle)
//   busy_o, done_o      - FSM in BUSY / one-cycle result-valid pulse
//   result_o            - last completed product, held until next completion
module mul_execute_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [3:0]  MUL_OP     = 4'b1110
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            ALU_Operation_i,
   input  logic                  valid_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] rs1_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  start_c;

   assign start_c = valid_i && (ALU_Operation_i == MUL_OP) && !flush_i;

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      busy_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               mcand_d  = rs1_data_i;
               mplier_d = rs2_data_i;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_BUSY;
               busy_d   = 1'b1;
            end
         end
         S_BUSY: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  // Final iteration: publish the product as we enter DONE
                  state_d  = S_DONE;
                  result_d = acc_d;
                  done_d   = 1'b1;
               end else begin
                  busy_d = 1'b1;
               end
            end
         end
         // DONE always returns to IDLE so the held MUL cannot relaunch
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // Stall covers the launch cycle as well as every BUSY cycle
   assign stall_o  = (state_q == S_BUSY) || ((state_q == S_IDLE) && start_c);
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mul_execute_unit.sv
// Directed bench for mul_execute_unit: reset, basic multiply timing,
// wrap/sign products, non-MUL codes, flush, back-to-back, async reset.
module tb_mul_execute_unit;

   localparam int unsigned DW = 32;
   localparam logic [3:0]  MUL = 4'b1110;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    op;
   logic          valid;
   logic          flush;
   logic [DW-1:0] rs1, rs2;
   logic          stall, busy, done;
   logic [DW-1:0] result;

   int checks   = 0;
   int failures = 0;

   mul_execute_unit #(.DATA_WIDTH(DW), .MUL_OP(MUL)) dut (
      .clk             (clk),
      .reset           (reset),
      .ALU_Operation_i (op),
      .valid_i         (valid),
      .flush_i         (flush),
      .rs1_data_i      (rs1),
      .rs2_data_i      (rs2),
      .stall_o         (stall),
      .busy_o          (busy),
      .done_o          (done),
      .result_o        (result)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic present(input logic [3:0] o, input logic v,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
      op = o; valid = v; rs1 = a; rs2 = b;
   endtask

   // Tick until done_o is seen or the budget runs out; returns cycles taken
   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 100);
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0;
      present(4'b0000, 1'b0, '0, '0);
      #3;
      checks++;
      if ({stall, busy, done} !== 3'b000 || result !== '0) begin
         failures++;
         $display("FAIL reset_outputs: stall/busy/done=%b result=%h want 000/0",
                  {stall, busy, done}, result);
      end
      tick(); tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({stall, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL reset_release: stall/busy/done=%b want 000", {stall, busy, done});
      end
   endtask

   task automatic test_basic();
      present(MUL, 1'b1, 32'd7, 32'd6);
      #1;
      checks++;
      if (stall !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL basic_issue: stall=%b busy=%b done=%b want 1 0 0", stall, busy, done);
      end
      for (int c = 1; c <= 33; c++) begin
         tick();
         checks++;
         if (c <= 32) begin
            if (stall !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
               failures++;
               $display("FAIL basic_busy c=%0d: stall=%b busy=%b done=%b want 1 1 0",
                        c, stall, busy, done);
            end
         end else begin
            if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || result !== 32'd42) begin
               failures++;
               $display("FAIL basic_done: stall=%b busy=%b done=%b result=%0d want 0 0 1 42",
                        stall, busy, done, result);
            end
         end
      end
      valid = 1'b0;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd42) begin
         failures++;
         $display("FAIL basic_after: done=%b busy=%b result=%0d want 0 0 42", done, busy, result);
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] a [4];
      logic [DW-1:0] b [4];
      logic [DW-1:0] e [4];
      int n;
      a[0] = 32'hFFFF_FFFF; b[0] = 32'hFFFF_FFFF; e[0] = 32'h0000_0001;
      a[1] = 32'h8000_0000; b[1] = 32'd2;        e[1] = 32'h0000_0000;
      a[2] = 32'h1234_5678; b[2] = 32'd0;        e[2] = 32'h0000_0000;
      a[3] = 32'hFFFF_FFFE; b[3] = 32'd3;        e[3] = 32'hFFFF_FFFA;
      for (int i = 0; i < 4; i++) begin
         present(MUL, 1'b1, a[i], b[i]);
         wait_done(n);
         checks++;
         if (n !== 33 || result !== e[i]) begin
            failures++;
            $display("FAIL wrap_%0d: cycles=%0d result=%h want 33 %h", i, n, result, e[i]);
         end
         valid = 1'b0;
         tick();
      end
   endtask

   task automatic test_non_mul();
      logic [3:0] o [3];
      logic       v [3];
      o[0] = 4'b0000; v[0] = 1'b1;
      o[1] = 4'b1000; v[1] = 1'b1;
      o[2] = MUL;     v[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         present(o[i], v[i], 32'd5, 32'd9);
         for (int c = 0; c < 40; c++) begin
            #1;
            checks++;
            if ({stall, busy, done} !== 3'b000 || result !== 32'hFFFF_FFFA) begin
               failures++;
               $display("FAIL non_mul_%0d c=%0d: stall/busy/done=%b result=%h want 000 fffffffa",
                        i, c, {stall, busy, done}, result);
            end
            tick();
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_flush();
      int n;
      present(MUL, 1'b1, 32'd7, 32'd6);
      wait_done(n);
      valid = 1'b0;
      tick();
      checks++;
      if (result !== 32'd42) begin
         failures++;
         $display("FAIL flush_prior: result=%0d want 42", result);
      end
      present(MUL, 1'b1, 32'd11, 32'd13);
      for (int c = 1; c <= 5; c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd42) begin
         failures++;
         $display("FAIL flush_busy: busy=%b done=%b stall=%b result=%0d want 0 0 0 42",
                  busy, done, stall, result);
      end
      for (int c = 0; c < 40; c++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd42) begin
            failures++;
            $display("FAIL flush_quiet c=%0d: done=%b busy=%b result=%0d want 0 0 42",
                     c, done, busy, result);
         end
      end
      // Flush in IDLE suppresses the launch
      present(MUL, 1'b1, 32'd3, 32'd3);
      flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_stall: stall=%b want 0", stall);
      end
      tick();
      flush = 1'b0;
      valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_busy: busy=%b want 0", busy);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int n1, n2;
      present(MUL, 1'b1, 32'd3, 32'd5);
      wait_done(n1);
      checks++;
      if (n1 !== 33 || result !== 32'd15 || stall !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first: cycles=%0d result=%0d stall=%b want 33 15 0", n1, result, stall);
      end
      // First MUL still held through DONE; the next instruction arrives after it
      tick();
      present(MUL, 1'b1, 32'd9, 32'd9);
      #1;
      checks++;
      if (stall !== 1'b1 || busy !== 1'b0 || result !== 32'd15) begin
         failures++;
         $display("FAIL b2b_relaunch: stall=%b busy=%b result=%0d want 1 0 15", stall, busy, result);
      end
      wait_done(n2);
      checks++;
      if (n1 + 1 + n2 !== 34 + 33 || result !== 32'd81) begin
         failures++;
         $display("FAIL b2b_second: gap=%0d result=%0d want 34 81", 1 + n2, result);
      end
      valid = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      present(MUL, 1'b1, 32'd7, 32'd6);
      for (int c = 1; c <= 10; c++) tick();
      valid = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if ({stall, busy, done} !== 3'b000 || result !== '0) begin
         failures++;
         $display("FAIL async_reset: stall/busy/done=%b result=%h want 000 0",
                  {stall, busy, done}, result);
      end
      tick();
      reset = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         checks++;
         if ({stall, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL async_idle c=%0d: stall/busy/done=%b want 000", c, {stall, busy, done});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_non_mul();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_execute_unit.md
Name: mul_execute_unit

Overview:
- Multi-cycle execute unit for the EX stage of the RISC-V pipeline; consumes the 4-bit ALU operation code produced by ALU control.
- Executes MUL (ALU operation code 4'b1110): RV32M low 32 bits of rs1*rs2, shift-add, one bit per cycle.
- Stalls the pipeline while busy; presents the product with a one-cycle done pulse. All other operation codes are ignored and left to the combinational ALU.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count = DATA_WIDTH
MUL_OP, 4'b1110, ALU operation code that launches a multiply

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
ALU_Operation_i  input  4  operation code from ALU control
valid_i  input  1  EX stage holds a valid, non-bubble instruction
flush_i  input  1  synchronous abort of an in-flight multiply
rs1_data_i  input  DATA_WIDTH  multiplicand
rs2_data_i  input  DATA_WIDTH  multiplier
stall_o  output  1  hold IF/ID/EX pipeline registers
busy_o  output  1  FSM in BUSY
done_o  output  1  one-cycle pulse, result_o newly valid
result_o  output  DATA_WIDTH  low DATA_WIDTH bits of product

Behaviour:
- Reset (reset=0, any time, async): state=IDLE, acc/operand registers=0, counter=0, result_o=0, done_o=0, busy_o=0. stall_o=0 unless an IDLE start condition is presented.
- start = valid_i && (ALU_Operation_i == MUL_OP) && !flush_i.
- IDLE:
  - On start: latch mcand=rs1, mplier=rs2, acc=0, counter=0; go BUSY.
  - stall_o is asserted combinationally in the start cycle.
- BUSY, each cycle:
  - If mplier[0], acc = acc + mcand (mod 2^DATA_WIDTH).
  - mcand <<= 1; mplier >>= 1; counter += 1.
  - After iteration DATA_WIDTH-1, go DONE. No early termination: latency is fixed.
  - stall_o=1 and busy_o=1.
  - ALU_Operation_i and operand inputs are ignored (values are latched).
- DONE:
  - result_o = acc; done_o=1 for exactly this cycle; stall_o=0. The pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally. The still-present MUL in EX must not relaunch.
- Timing (issue cycle N): BUSY N+1..N+32; DONE N+33; stall_o high N..N+32 (33 cycles).
- result_o holds the last product until the next DONE; it is not cleared by flush.
- Back-to-back: a MUL presented in the cycle after DONE starts normally from IDLE.
- flush_i=1:
  - In BUSY: go IDLE next edge; done_o stays 0; result_o unchanged.
  - In IDLE: suppresses start.
  - In DONE: no effect (the done pulse still occurs).
- Signedness irrelevant: low-half product is identical for signed and unsigned operands.
- Non-MUL codes, or valid_i=0: no state change, stall_o=0.

Test Plan:
- Basic multiply: reset, then valid_i=1, op=4'b1110, rs1=7, rs2=6 at cycle N -> stall_o high N..N+32; done_o=1 only at N+33; result_o=42 from N+33.
- Wrap and sign cases:
  - 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001.
  - 0x80000000*2 -> 0x00000000.
  - 0x12345678*0 -> 0.
  - 0xFFFFFFFE(-2)*3 -> 0xFFFFFFFA.
- Non-MUL codes: op=4'b0000 and op=4'b1000 with valid_i=1; op=4'b1110 with valid_i=0 -> stall_o, busy_o, done_o stay 0 for 40 cycles; result_o unchanged.
- Async reset mid-op: drop reset at BUSY cycle 10 (between clock edges) -> outputs 0 immediately; after release with valid_i=0, FSM idle, no done_o.
- Flush mid-op: flush_i at BUSY cycle 5 after a prior result 42 -> IDLE next edge, no done_o, result_o stays 42.
- Back-to-back: 3*5 then 9*9 in consecutive instructions -> done pulses 34 cycles apart with results 15 then 81; the first MUL is not re-executed after its DONE.
